// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    typedef enum logic {
        PORT_IF,
        PORT_D
    } port_t;

    localparam logic [2:0] FUNCT3_WORD = 3'b010;

    // One memory access as captured from the winning port.
    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side request ports and memory-side control bundle of the arbiter.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_funct3;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic        mem_write_enable;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_write_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_address;
    logic [31:0] mem_read_data;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_funct3, mem_read_data,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_write_enable, mem_funct3, mem_write_address, mem_write_data, mem_read_address
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_funct3, mem_read_data,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_write_enable, mem_funct3, mem_write_address, mem_write_data, mem_read_address
    );
endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection: data priority, fetch forced after STARVE_LIMIT consecutive data wins.
// Latency: combinational winner; starvation count updates on the sampling edge.
// Backpressure: none of its own; only counts while the arbiter is sampling.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  sample,
    input  logic  if_req,
    input  logic  d_req,
    output logic  any_req,
    output port_t winner
);

    logic [3:0] starve_cnt;
    logic       fetch_forced;

    assign fetch_forced = (starve_cnt == 4'(STARVE_LIMIT));

    always_comb begin
        any_req = if_req | d_req;
        winner  = PORT_IF;
        if (d_req && !(if_req && fetch_forced)) begin
            winner = PORT_D;
        end
    end

    // Counts only data wins that actually made a fetch wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (sample) begin
            if (!if_req || winner == PORT_IF) begin
                starve_cnt <= '0;
            end else if (!fetch_forced) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory between instruction fetch and load/store with per-port request/grant.
// Latency: gnt one cycle after sampling in IDLE; read rvalid MEM_LATENCY cycles after gnt.
// Backpressure: requests are held until gnt; no queueing, one access in flight at a time.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    state_t      state, state_nxt;
    port_t       owner, winner;
    req_t        pick_req;
    logic        any_req;
    logic        accept;
    logic        store_q;
    logic        rsp_done;
    logic [15:0] wait_cnt;
    logic [31:0] raddr_q, waddr_q, wdata_q;
    logic [2:0]  funct3_q;

    mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .clk     (clk),
        .rst_n   (rst_n),
        .sample  (state == IDLE),
        .if_req  (bus.if_req),
        .d_req   (bus.d_req),
        .any_req (any_req),
        .winner  (winner)
    );

    always_comb begin
        pick_req = '{we: 1'b0, funct3: FUNCT3_WORD, addr: bus.if_addr, wdata: 32'd0};
        if (winner == PORT_D) begin
            pick_req = '{we: bus.d_we, funct3: bus.d_funct3, addr: bus.d_addr, wdata: bus.d_wdata};
        end
    end

    assign accept   = (state == IDLE) && any_req;
    assign rsp_done = (state == WAIT) && (wait_cnt == 16'd1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = store_q ? IDLE : WAIT;
            // <= 1 so a stray zero count can never park the FSM in WAIT.
            WAIT:    if (wait_cnt <= 16'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory-facing registers load on accept so they are already valid in ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= PORT_IF;
            store_q  <= 1'b0;
            wait_cnt <= '0;
            raddr_q  <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            funct3_q <= FUNCT3_WORD;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner    <= winner;
                store_q  <= pick_req.we;
                funct3_q <= pick_req.funct3;
                if (pick_req.we) begin
                    waddr_q <= pick_req.addr;
                    wdata_q <= pick_req.wdata;
                end else begin
                    raddr_q <= pick_req.addr;
                end
            end
            if (state == ISSUE) begin
                wait_cnt <= 16'(MEM_LATENCY);
            end else if (state == WAIT && wait_cnt != 16'd0) begin
                wait_cnt <= wait_cnt - 16'd1;
            end
        end
    end

    assign bus.if_gnt            = (state == ISSUE) && (owner == PORT_IF);
    assign bus.d_gnt             = (state == ISSUE) && (owner == PORT_D);
    assign bus.if_rvalid         = rsp_done && (owner == PORT_IF);
    assign bus.d_rvalid          = rsp_done && (owner == PORT_D);
    assign bus.if_rdata          = (rsp_done && owner == PORT_IF) ? bus.mem_read_data : 32'd0;
    assign bus.d_rdata           = (rsp_done && owner == PORT_D)  ? bus.mem_read_data : 32'd0;
    assign bus.mem_write_enable  = (state == ISSUE) && store_q;
    assign bus.mem_funct3        = funct3_q;
    assign bus.mem_write_address = waddr_q;
    assign bus.mem_write_data    = wdata_q;
    assign bus.mem_read_address  = raddr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance A (latency 1) via vector table + scoreboard, instance B (latency 2) via directed sequences.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n, rst_b_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if ifa ();
    mem_arbiter_if ifb ();

    mem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u_a (.clk(clk), .rst_n(rst_a_n), .bus(ifa.slave));
    mem_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(4)) u_b (.clk(clk), .rst_n(rst_b_n), .bus(ifb.slave));

    function automatic logic [31:0] init_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        case (w)
            32'h0000_0000: return 32'hA5A5_A5A5;
            32'h0000_0010: return 32'h0050_0093;
            32'h0000_0024: return 32'h1122_3344;
            default:       return w ^ 32'h5A5A_0000;
        endcase
    endfunction

    // Memory models: word-indexed, funct3 ignored, unwritten words come from init_word.
    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];
    logic [63:0] wr_a = '0;
    logic [63:0] wr_b = '0;
    logic [31:0] rd_a, rd_b1, rd_b;

    always @(posedge clk) begin
        if (ifa.mem_write_enable) begin
            mem_a[ifa.mem_write_address[7:2]] <= ifa.mem_write_data;
            wr_a[ifa.mem_write_address[7:2]]  <= 1'b1;
        end
        rd_a <= wr_a[ifa.mem_read_address[7:2]] ? mem_a[ifa.mem_read_address[7:2]]
                                                : init_word(ifa.mem_read_address);
        if (ifb.mem_write_enable) begin
            mem_b[ifb.mem_write_address[7:2]] <= ifb.mem_write_data;
            wr_b[ifb.mem_write_address[7:2]]  <= 1'b1;
        end
        rd_b1 <= wr_b[ifb.mem_read_address[7:2]] ? mem_b[ifb.mem_read_address[7:2]]
                                                 : init_word(ifb.mem_read_address);
        rd_b  <= rd_b1;
    end

    assign ifa.mem_read_data = rd_a;
    assign ifb.mem_read_data = rd_b;

    a_if_hold_a: assert property (@(posedge clk) disable iff (!rst_a_n)
        (ifa.if_req && !ifa.if_gnt) |=> (ifa.if_req && $stable(ifa.if_addr)));
    a_d_hold_a: assert property (@(posedge clk) disable iff (!rst_a_n)
        (ifa.d_req && !ifa.d_gnt) |=> (ifa.d_req && $stable({ifa.d_we, ifa.d_addr, ifa.d_wdata, ifa.d_funct3})));
    a_if_hold_b: assert property (@(posedge clk) disable iff (!rst_b_n)
        (ifb.if_req && !ifb.if_gnt) |=> (ifb.if_req && $stable(ifb.if_addr)));
    a_d_hold_b: assert property (@(posedge clk) disable iff (!rst_b_n)
        (ifb.d_req && !ifb.d_gnt) |=> (ifb.d_req && $stable({ifb.d_we, ifb.d_addr, ifb.d_wdata, ifb.d_funct3})));

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Scoreboard for instance A read responses.
    typedef struct {
        logic        port_d;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst_a_n === 1'b1) begin
            if (ifa.if_rvalid || ifa.d_rvalid) begin
                chk1("a_single_rvalid", ifa.if_rvalid & ifa.d_rvalid, 1'b0);
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL a_rvalid_unexpected actual=if:%b d:%b required=none at cyc %0d",
                             ifa.if_rvalid, ifa.d_rvalid, cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk1("a_rsp_port", ifa.d_rvalid, e.port_d);
                    chk32("a_rsp_data", e.port_d ? ifa.d_rdata : ifa.if_rdata, e.data);
                    if (e.cyc >= 0) chki("a_rsp_cycle", cyc, e.cyc);
                end
            end
            if (!ifa.if_rvalid) chk32("a_if_rdata_idle", ifa.if_rdata, 32'd0);
            if (!ifa.d_rvalid)  chk32("a_d_rdata_idle", ifa.d_rdata, 32'd0);
        end
    end

    task automatic wait_gnt(input bit on_b, input bit port_d, output int at);
        at = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (on_b ? (port_d ? ifb.d_gnt : ifb.if_gnt) : (port_d ? ifa.d_gnt : ifa.if_gnt)) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_rv_b(output int at, output logic [31:0] dat);
        at  = -1;
        dat = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifb.if_rvalid) begin
                at  = cyc;
                dat = ifb.if_rdata;
                break;
            end
        end
    endtask

    task automatic chk_rst(input bit on_b, input string tag);
        logic [4:0]  ctl;
        logic [31:0] rdat, ra, wa, wd;
        logic [2:0]  f3;
        ctl  = on_b ? {ifb.if_gnt, ifb.d_gnt, ifb.if_rvalid, ifb.d_rvalid, ifb.mem_write_enable}
                    : {ifa.if_gnt, ifa.d_gnt, ifa.if_rvalid, ifa.d_rvalid, ifa.mem_write_enable};
        rdat = on_b ? (ifb.if_rdata | ifb.d_rdata) : (ifa.if_rdata | ifa.d_rdata);
        ra   = on_b ? ifb.mem_read_address  : ifa.mem_read_address;
        wa   = on_b ? ifb.mem_write_address : ifa.mem_write_address;
        wd   = on_b ? ifb.mem_write_data    : ifa.mem_write_data;
        f3   = on_b ? ifb.mem_funct3        : ifa.mem_funct3;
        chk32({tag, "_ctrl"}, 32'(ctl), 32'd0);
        chk32({tag, "_rdata"}, rdat, 32'd0);
        chk32({tag, "_raddr"}, ra, 32'd0);
        chk32({tag, "_waddr"}, wa, 32'd0);
        chk32({tag, "_wdata"}, wd, 32'd0);
        chk32({tag, "_funct3"}, 32'(f3), 32'(3'b010));
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic run_txn_a(input vec_t v, input int idx);
        int c0, at;
        @(posedge clk); #1;
        c0 = cyc;
        if (v.is_d) begin
            ifa.d_req = 1'b1; ifa.d_we = v.we; ifa.d_addr = v.addr;
            ifa.d_wdata = v.wdata; ifa.d_funct3 = v.f3;
        end else begin
            ifa.if_req = 1'b1; ifa.if_addr = v.addr;
        end
        if (!v.we) sb_q.push_back('{port_d: v.is_d, data: v.exp_rdata, cyc: c0 + 2});
        wait_gnt(1'b0, v.is_d, at);
        chki($sformatf("v%0d_gnt_cycle", idx), at, c0 + 1);
        chk1($sformatf("v%0d_other_gnt", idx), v.is_d ? ifa.if_gnt : ifa.d_gnt, 1'b0);
        chk1($sformatf("v%0d_mem_we", idx), ifa.mem_write_enable, v.we);
        if (v.we) begin
            chk32($sformatf("v%0d_waddr", idx), ifa.mem_write_address, v.addr);
            chk32($sformatf("v%0d_wdata", idx), ifa.mem_write_data, v.wdata);
            chk32($sformatf("v%0d_funct3", idx), 32'(ifa.mem_funct3), 32'(v.f3));
        end else begin
            chk32($sformatf("v%0d_raddr", idx), ifa.mem_read_address, v.addr);
            chk32($sformatf("v%0d_funct3", idx), 32'(ifa.mem_funct3), v.is_d ? 32'(v.f3) : 32'(3'b010));
        end
        @(posedge clk); #1;
        ifa.if_req = 1'b0;
        ifa.d_req  = 1'b0;
        @(negedge clk);
        chk1($sformatf("v%0d_we_one_cycle", idx), ifa.mem_write_enable, 1'b0);
        repeat (2) @(posedge clk);
    endtask

    vec_t vecs[7];

    initial begin
        #100000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          c0, at, at2, ng, rv;
        logic [5:0]  order;
        logic [31:0] dat;

        vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,         3'b010, 32'h0050_0093};
        vecs[1] = '{1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 3'b010, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 32'h20, 32'h0,         3'b010, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b0, 32'h24, 32'h0,         3'b010, 32'h1122_3344};
        vecs[4] = '{1'b1, 1'b1, 32'h28, 32'hCAFE_F00D, 3'b010, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 32'h28, 32'h0,         3'b100, 32'hCAFE_F00D};
        vecs[6] = '{1'b0, 1'b0, 32'h0,  32'h0,         3'b010, 32'hA5A5_A5A5};

        rst_a_n = 1'b0; rst_b_n = 1'b0;
        ifa.if_req = 0; ifa.if_addr = '0; ifa.d_req = 0; ifa.d_we = 0;
        ifa.d_addr = '0; ifa.d_wdata = '0; ifa.d_funct3 = 3'b010;
        ifb.if_req = 0; ifb.if_addr = '0; ifb.d_req = 0; ifb.d_we = 0;
        ifb.d_addr = '0; ifb.d_wdata = '0; ifb.d_funct3 = 3'b010;
        repeat (2) @(posedge clk); #1;
        chk_rst(1'b0, "a_reset");
        chk_rst(1'b1, "b_reset");
        chk32("a_starve_reset", 32'(u_a.u_pick.starve_cnt), 32'd0);
        @(posedge clk); #1;
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) run_txn_a(vecs[i], i);

        // Simultaneous fetch and load: data first, fetch at the next IDLE.
        @(posedge clk); #1;
        c0 = cyc;
        ifa.if_req = 1'b1; ifa.if_addr = 32'h10;
        ifa.d_req = 1'b1; ifa.d_we = 1'b0; ifa.d_addr = 32'h24; ifa.d_funct3 = 3'b010;
        sb_q.push_back('{port_d: 1'b1, data: 32'h1122_3344, cyc: c0 + 2});
        sb_q.push_back('{port_d: 1'b0, data: 32'h0050_0093, cyc: c0 + 5});
        wait_gnt(1'b0, 1'b1, at);
        chki("both_d_gnt_cycle", at, c0 + 1);
        chk1("both_if_waits", ifa.if_gnt, 1'b0);
        @(posedge clk); #1;
        ifa.d_req = 1'b0;
        wait_gnt(1'b0, 1'b0, at2);
        chki("both_if_gnt_cycle", at2, at + 3);
        @(posedge clk); #1;
        ifa.if_req = 1'b0;
        repeat (3) @(posedge clk);

        // Both ports held: four data wins, then a forced fetch.
        @(posedge clk); #1;
        ifa.if_req = 1'b1; ifa.if_addr = 32'h10;
        ifa.d_req = 1'b1; ifa.d_we = 1'b1; ifa.d_addr = 32'h40;
        ifa.d_wdata = 32'h1234_5678; ifa.d_funct3 = 3'b010;
        sb_q.push_back('{port_d: 1'b0, data: 32'h0050_0093, cyc: -1});
        ng = 0; order = '0;
        for (int i = 0; i < 60 && ng < 6; i++) begin
            @(negedge clk);
            if (ifa.if_gnt || ifa.d_gnt) begin
                order[ng] = ifa.d_gnt;
                if (ng == 3) chk32("starve_cnt_at_limit", 32'(u_a.u_pick.starve_cnt), 32'd4);
                ng++;
                if (ifa.if_gnt) begin
                    chk32("starve_cnt_after_fetch", 32'(u_a.u_pick.starve_cnt), 32'd0);
                    @(posedge clk); #1;
                    ifa.if_req = 1'b0;
                end
            end
        end
        chki("starve_grant_count", ng, 6);
        chk32("starve_order", 32'(order), 32'h2F);
        @(posedge clk); #1;
        ifa.d_req = 1'b0;
        repeat (4) @(posedge clk);

        // Instance B: latency-2 fetch, next request accepted once back in IDLE.
        @(posedge clk); #1;
        c0 = cyc;
        ifb.if_req = 1'b1; ifb.if_addr = 32'h0;
        wait_gnt(1'b1, 1'b0, at);
        chki("b_fetch_gnt_cycle", at, c0 + 1);
        chk32("b_fetch_funct3", 32'(ifb.mem_funct3), 32'(3'b010));
        @(posedge clk); #1;
        ifb.if_req = 1'b0;
        ifb.d_req = 1'b1; ifb.d_we = 1'b1; ifb.d_addr = 32'h40;
        ifb.d_wdata = 32'h0BAD_F00D; ifb.d_funct3 = 3'b010;
        wait_rv_b(at, dat);
        chki("b_fetch_rvalid_cycle", at, c0 + 3);
        chk32("b_fetch_rdata", dat, 32'hA5A5_A5A5);
        wait_gnt(1'b1, 1'b1, at);
        chki("b_next_accept_gnt_cycle", at, c0 + 5);
        @(posedge clk); #1;
        ifb.d_req = 1'b0;
        repeat (3) @(posedge clk);

        // Instance B: reset pulse while a read sits in WAIT.
        @(posedge clk); #1;
        c0 = cyc;
        ifb.if_req = 1'b1; ifb.if_addr = 32'h10;
        wait_gnt(1'b1, 1'b0, at);
        chki("b_rst_fetch_gnt_cycle", at, c0 + 1);
        @(posedge clk); #1;
        ifb.if_req = 1'b0;
        rst_b_n = 1'b0;
        #2;
        chk_rst(1'b1, "b_midwait_rst");
        @(posedge clk); #1;
        rst_b_n = 1'b1;
        rv = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ifb.if_rvalid || ifb.d_rvalid) rv++;
        end
        chki("b_no_rvalid_after_rst", rv, 0);

        @(posedge clk); #1;
        c0 = cyc;
        ifb.if_req = 1'b1; ifb.if_addr = 32'h20;
        wait_gnt(1'b1, 1'b0, at);
        chki("b_fresh_gnt_cycle", at, c0 + 1);
        @(posedge clk); #1;
        ifb.if_req = 1'b0;
        wait_rv_b(at, dat);
        chki("b_fresh_rvalid_cycle", at, c0 + 3);
        chk32("b_fresh_rdata", dat, 32'h5A5A_0020);
        repeat (4) @(posedge clk);

        chki("a_scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
